// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode-and-issue stage with 2-entry buffer in front of the 64-bit ALU
module alu_issue_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_class,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    // 4'b1100 (NOR) is reserved for future decode extensions.

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } count_t;

    count_t r_count;
    count_t w_count_nxt;

    logic [XLEN-1:0]  r_head_a, r_head_b, r_tail_a, r_tail_b;
    logic [3:0]       r_head_op, r_tail_op;
    logic             r_head_ill, r_tail_ill;
    logic [CNT_W-1:0] r_ill_cnt;

    logic [XLEN-1:0] w_dec_b;
    logic [3:0]      w_dec_op;
    logic            w_dec_ill;
    logic            w_push, w_pop;
    logic            w_head_from_in, w_head_from_tail, w_tail_from_in;

    // Translate the instruction slice into ALU op and operand B; unsupported funct3 falls back to ADD
    always_comb begin
        w_dec_op  = OP_ADD;
        w_dec_b   = imm;
        w_dec_ill = 1'b0;
        case (op_class)
            2'b00: begin
                w_dec_op = OP_ADD;
                w_dec_b  = imm;
            end
            2'b01: begin
                w_dec_op = OP_SUB;
                w_dec_b  = rs2_data;
            end
            2'b10: begin
                w_dec_b = rs2_data;
                case (funct3)
                    3'b000:  w_dec_op = funct7_5 ? OP_SUB : OP_ADD;
                    3'b111:  w_dec_op = OP_AND;
                    3'b110:  w_dec_op = OP_OR;
                    default: w_dec_ill = 1'b1;
                endcase
            end
            default: begin
                w_dec_b = imm;
                case (funct3)
                    3'b000:  w_dec_op = OP_ADD;
                    3'b111:  w_dec_op = OP_AND;
                    3'b110:  w_dec_op = OP_OR;
                    default: w_dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    // Handshakes look only at registered occupancy, so in_ready never depends on out_ready
    assign in_ready  = (r_count != S_FULL);
    assign out_valid = (r_count != S_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Occupancy next-state and which buffer slot each cycle loads
    always_comb begin
        w_count_nxt      = r_count;
        w_head_from_in   = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_from_in   = 1'b0;
        case (r_count)
            S_EMPTY: begin
                if (w_push) begin
                    w_count_nxt    = S_ONE;
                    w_head_from_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    w_head_from_in = 1'b1;
                end else if (w_push) begin
                    w_count_nxt    = S_FULL;
                    w_tail_from_in = 1'b1;
                end else if (w_pop) begin
                    w_count_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_count_nxt      = S_ONE;
                    w_head_from_tail = 1'b1;
                end
            end
            default: w_count_nxt = S_EMPTY;
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= S_EMPTY;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Head and tail entry storage; head feeds the ALU outputs directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_a   <= '0;
            r_head_b   <= '0;
            r_head_op  <= OP_AND;
            r_head_ill <= 1'b0;
            r_tail_a   <= '0;
            r_tail_b   <= '0;
            r_tail_op  <= OP_AND;
            r_tail_ill <= 1'b0;
        end else begin
            if (w_head_from_in) begin
                r_head_a   <= rs1_data;
                r_head_b   <= w_dec_b;
                r_head_op  <= w_dec_op;
                r_head_ill <= w_dec_ill;
            end else if (w_head_from_tail) begin
                r_head_a   <= r_tail_a;
                r_head_b   <= r_tail_b;
                r_head_op  <= r_tail_op;
                r_head_ill <= r_tail_ill;
            end
            if (w_tail_from_in) begin
                r_tail_a   <= rs1_data;
                r_tail_b   <= w_dec_b;
                r_tail_op  <= w_dec_op;
                r_tail_ill <= w_dec_ill;
            end
        end
    end

    // Saturating count of illegal encodings accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ill_cnt <= '0;
        end else if (w_push && w_dec_ill && (r_ill_cnt != {CNT_W{1'b1}})) begin
            r_ill_cnt <= r_ill_cnt + CNT_W'(1);
        end
    end

    assign alu_a       = r_head_a;
    assign alu_b       = r_head_b;
    assign alu_op      = r_head_op;
    assign illegal     = r_head_ill;
    assign illegal_cnt = r_ill_cnt;

endmodule
